// File: rtl/btn_conditioner_pkg.sv
// Shared constants for the calc input front end: default synchroniser/debounce
// depths and the op-select bit positions used by the ALU decode.
package btn_conditioner_pkg;

    localparam int BTN_SYNC_STAGES    = 2;
    localparam int BTN_DEBOUNCE_SIM   = 4;
    localparam int BTN_DEBOUNCE_BOARD = 1_000_000;

    localparam int OP_BIT_L = 2;
    localparam int OP_BIT_C = 1;
    localparam int OP_BIT_R = 0;

    typedef struct packed {
        logic btnl;
        logic btnc;
        logic btnr;
    } op_sel_t;

endpackage

// File: rtl/btn_conditioner_debounce_bit.sv
// One button lane: synchroniser chain, run-length counter and stable register.
// rise flags the edge at which the stable value is about to go 0->1.
module debounce_bit
    import btn_conditioner_pkg::*;
#(
    parameter int SYNC_STAGES     = BTN_SYNC_STAGES,
    parameter int DEBOUNCE_CYCLES = BTN_DEBOUNCE_SIM
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic level,
    output logic rise
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   stable_q, stable_d;
    logic                   synced;

    // The count only survives while the synced value keeps disagreeing with
    // the stable one; the final increment commits the new value instead.
    always_comb begin
        sync_d   = {sync_q[SYNC_STAGES-2:0], din};
        synced   = sync_q[SYNC_STAGES-1];
        cnt_d    = '0;
        stable_d = stable_q;
        if (synced != stable_q) begin
            if (cnt_q == CNT_LAST) begin
                stable_d = synced;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q   <= '0;
            cnt_q    <= '0;
            stable_q <= 1'b0;
        end else begin
            sync_q   <= sync_d;
            cnt_q    <= cnt_d;
            stable_q <= stable_d;
        end
    end

    assign level = stable_q;
    assign rise  = stable_d & ~stable_q;

endmodule

// File: rtl/btn_conditioner.sv
// Board-pin front end for calc: debounced op buttons, a one-shot accumulate
// strobe and a switch snapshot frozen at that strobe.
module btn_conditioner
    import btn_conditioner_pkg::*;
#(
    parameter int SYNC_STAGES     = BTN_SYNC_STAGES,
    parameter int DEBOUNCE_CYCLES = BTN_DEBOUNCE_SIM
) (
    input  logic        clk,
    input  logic        btnu,
    input  logic        btnl_in,
    input  logic        btnc_in,
    input  logic        btnr_in,
    input  logic        btnd_in,
    input  logic [15:0] sw_in,
    output logic        btnl,
    output logic        btnc,
    output logic        btnr,
    output logic        btnd_pulse,
    output logic [15:0] sw_q
);

    logic [2:0] op_raw, op_level_v, unused_op_rise;
    op_sel_t    op_level;
    logic       btnd_rise;

    logic [SYNC_STAGES-1:0][15:0] sw_sync_q, sw_sync_d;
    logic [15:0]                  sw_snap_q, sw_snap_d;
    logic                         pulse_q, pulse_d;

    always_comb begin
        op_raw           = '0;
        op_raw[OP_BIT_L] = btnl_in;
        op_raw[OP_BIT_C] = btnc_in;
        op_raw[OP_BIT_R] = btnr_in;
    end

    for (genvar i = 0; i < 3; i++) begin : g_op
        debounce_bit #(
            .SYNC_STAGES    (SYNC_STAGES),
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_op (
            .clk  (clk),
            .rst  (btnu),
            .din  (op_raw[i]),
            .level(op_level_v[i]),
            .rise (unused_op_rise[i])
        );
    end

    debounce_bit #(
        .SYNC_STAGES    (SYNC_STAGES),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_btnd (
        .clk  (clk),
        .rst  (btnu),
        .din  (btnd_in),
        .level(),
        .rise (btnd_rise)
    );

    // Switches bounce freely; they only need to be settled when the strobe samples them.
    always_comb begin
        sw_sync_d = {sw_sync_q[SYNC_STAGES-2:0], sw_in};
        pulse_d   = btnd_rise;
        sw_snap_d = btnd_rise ? sw_sync_q[SYNC_STAGES-1] : sw_snap_q;
    end

    always_ff @(posedge clk or posedge btnu) begin
        if (btnu) begin
            sw_sync_q <= '0;
            sw_snap_q <= '0;
            pulse_q   <= 1'b0;
        end else begin
            sw_sync_q <= sw_sync_d;
            sw_snap_q <= sw_snap_d;
            pulse_q   <= pulse_d;
        end
    end

    assign op_level   = op_sel_t'(op_level_v);
    assign btnl       = op_level.btnl;
    assign btnc       = op_level.btnc;
    assign btnr       = op_level.btnr;
    assign btnd_pulse = pulse_q;
    assign sw_q       = sw_snap_q;

endmodule

// File: doc/btn_conditioner.md
Name: btn_conditioner

Overview:
- Front-end input stage between the board pins and the calc accumulator.
- Synchronises and debounces the operation buttons (btnl, btnc, btnr) and the accumulate button (btnd), and synchronises the 16-bit switch bus.
- Emits a single-cycle accumulate strobe together with a frozen operand snapshot, so calc sees one clean update per physical press.

Parameters:
- SYNC_STAGES, 2, flip-flop depth of each synchroniser chain; minimum 2.
- DEBOUNCE_CYCLES, 4, consecutive cycles an input must differ from its stable value before that value changes; minimum 1. Board build uses 1_000_000.

Ports:
- clk  in  1  system clock, rising-edge.
- btnu  in  1  reset: asynchronous, active-high.
- btnl_in  in  1  raw op-select button, left.
- btnc_in  in  1  raw op-select button, centre.
- btnr_in  in  1  raw op-select button, right.
- btnd_in  in  1  raw accumulate button.
- sw_in  in  16  raw switch bus.
- btnl  out  1  debounced level.
- btnc  out  1  debounced level.
- btnr  out  1  debounced level.
- btnd_pulse  out  1  one-cycle strobe on the debounced rising edge of btnd.
- sw_q  out  16  operand snapshot, valid from the cycle btnd_pulse is high.

Behaviour:
- Reset (btnu=1, async): clears every synchroniser flop, debounce counter, stable register and sw_q to 0. All outputs read 0 immediately and stay 0 while btnu=1.
- Synchroniser per bit: SYNC_STAGES flops. Edge 0 captures the raw value; the last stage presents it after edge SYNC_STAGES-1.
- Debounce per button:
  - Counter width is $clog2(DEBOUNCE_CYCLES+1).
  - At each edge, if synced == stable, the counter clears.
  - Otherwise the counter increments. When it reaches DEBOUNCE_CYCLES, stable <= synced and the counter clears in the same edge.
- Latency: a raw change held steady changes the stable value at the (SYNC_STAGES+DEBOUNCE_CYCLES)-th rising edge after its setup (6 with defaults).
- Glitches:
  - A synced excursion shorter than DEBOUNCE_CYCLES cycles resets the counter and never reaches the outputs.
  - A glitch back to the stable value mid-count restarts the count from 0.
- btnd_pulse: registered, high exactly one cycle after the edge at which stable_btnd goes 0->1.
  - Never high on a 1->0 transition.
  - A held button yields exactly one pulse.
- sw_q: loaded from the synchronised sw bus at the same edge that raises btnd_pulse; holds its value otherwise. It therefore stays constant for the entire accumulate cycle.
- Op levels (btnl, btnc, btnr) are the stable registers, each independent of the others.
  - Simultaneous changes on several buttons are debounced independently; no priority between them.
- Reset mid-debounce aborts the count.
  - A button held through reset release is treated as a new press: after full latency, its stable value becomes 1 and btnd produces one pulse.
- sw_in is not debounced, only synchronised. The snapshot tolerates switch bounce because it is taken only at the strobe.
- No combinational path from any input to any output.

Decomposition:
- Shared Verilog header (included like the other calc sources) holds:
  - Default constants BTN_SYNC_STAGES=2, BTN_DEBOUNCE_SIM=4, BTN_DEBOUNCE_BOARD=1_000_000.
  - Op-select bit positions {btnl, btnc, btnr} used by calc's ALU decode.
- One sub-module, debounce_bit: synchroniser + counter + stable register for one bit, with the same parameters.
  - Instantiated four times; the sw bus uses synchroniser flops only.
- Top-level owns the btnd edge detector and the sw_q register.

Test Plan (SYNC_STAGES=2, DEBOUNCE_CYCLES=4, 20 ns clock):
- Clean press: btnd_in 0->1 held 20 cycles with sw_in=16'h1234 -> btnd_pulse high for exactly one cycle, after the 6th edge; sw_q=16'h1234 from that cycle; no further pulse while held or on release.
- Bounce: btnd_in toggles 1,0,1,0 every cycle, then holds 1 -> zero pulses during the bounce; exactly one pulse 6 edges after the final stable 1.
- Short glitch: btnl_in high for 3 cycles, then low -> btnl never leaves 0; next 5-cycle press raises btnl at the 6th edge.
- Operand freeze: pulse with sw_in=16'h0ff0, then sw_in->16'hffff with no press -> sw_q stays 16'h0ff0 until the next pulse.
- Simultaneous buttons: btnl_in, btnc_in, btnr_in all rise on the same edge -> all three outputs go high at the same (6th) edge; btnd_pulse stays 0.
- Reset mid-operation: btnu pulsed while counters are partway and sw_q=16'h324f -> all outputs 0 asynchronously, before the next edge. With btnd_in still held, exactly one pulse follows 6 edges after reset release.
